// File: rtl/cntry_vehicle_sensor_pkg.sv
// Shared definitions for the country-road vehicle sensor and the light controller:
// light codes and default timing/queue parameters.
package cntry_vehicle_sensor_pkg;

  typedef enum logic [1:0] {
    LightRed    = 2'd0,
    LightYellow = 2'd1,
    LightGreen  = 2'd2
  } light_e;

  localparam logic [1:0] LightIllegal = 2'd3;

  localparam int unsigned DefDebCycles    = 4;
  localparam int unsigned DefDepartCycles = 3;
  localparam int unsigned DefQmax         = 15;
  localparam int unsigned QueueW          = 4;

  function automatic logic is_green(input logic [1:0] code);
    return code == LightGreen;
  endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Two-flop synchronizer followed by a stable-count debouncer for the loop detector.
module sensor_debounce
  import cntry_vehicle_sensor_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DefDebCycles
) (
  input  logic clock,
  input  logic clear_n,
  input  logic din,
  output logic dout
);

  localparam int unsigned    CntW    = $clog2(DEB_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic            q1_q, q2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Toggle on the edge where the count would reach DEB_CYCLES; any agreement restarts it.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (q2_q != level_q) begin
      if (cnt_q == CntLast) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      q1_q    <= 1'b0;
      q2_q    <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      q1_q    <= din;
      q2_q    <= q1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dout = level_q;

endmodule

// File: rtl/cntry_vehicle_sensor.sv
// Country-road vehicle queue: counts debounced loop arrivals and timed green departures,
// and raises the vehicle-waiting request X while the queue is non-empty.
module cntry_vehicle_sensor
  import cntry_vehicle_sensor_pkg::*;
#(
  parameter int unsigned DEB_CYCLES    = DefDebCycles,
  parameter int unsigned DEPART_CYCLES = DefDepartCycles,
  parameter int unsigned QMAX          = DefQmax
) (
  input  logic              clock,
  input  logic              clear_n,
  input  logic              loop_raw,
  input  logic [1:0]        cntry,
  output logic              X,
  output logic [QueueW-1:0] queue_cnt,
  output logic              overflow,
  output logic              light_err
);

  localparam int unsigned      TmrW     = (DEPART_CYCLES > 1) ? $clog2(DEPART_CYCLES) : 1;
  localparam logic [TmrW-1:0]  TmrLast  = TmrW'(DEPART_CYCLES - 1);
  localparam logic [QueueW-1:0] QmaxVal = QueueW'(QMAX);

  logic              deb_level;
  logic              deb_prev_q;
  logic [TmrW-1:0]   tmr_q, tmr_d;
  logic [QueueW-1:0] queue_q, queue_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;
  logic              arrival, depart, green, busy;

  sensor_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_debounce (
    .clock  (clock),
    .clear_n(clear_n),
    .din    (loop_raw),
    .dout   (deb_level)
  );

  // The illegal code 3 fails is_green, so it also clears the depart timer.
  always_comb begin
    arrival = deb_level & ~deb_prev_q;
    green   = is_green(cntry);
    busy    = (queue_q != '0);
    depart  = green && busy && (tmr_q == TmrLast);

    tmr_d = tmr_q;
    if (!green) begin
      tmr_d = '0;
    end else if (busy) begin
      tmr_d = depart ? '0 : tmr_q + TmrW'(1);
    end

    queue_d = queue_q;
    ovf_d   = ovf_q;
    if (arrival && !depart) begin
      if (queue_q == QmaxVal) begin
        ovf_d = 1'b1;
      end else begin
        queue_d = queue_q + QueueW'(1);
      end
    end else if (depart && !arrival) begin
      queue_d = queue_q - QueueW'(1);
    end

    err_d = err_q | (cntry == LightIllegal);
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      deb_prev_q <= 1'b0;
      tmr_q      <= '0;
      queue_q    <= '0;
      ovf_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      deb_prev_q <= deb_level;
      tmr_q      <= tmr_d;
      queue_q    <= queue_d;
      ovf_q      <= ovf_d;
      err_q      <= err_d;
    end
  end

  assign X         = busy;
  assign queue_cnt = queue_q;
  assign overflow  = ovf_q;
  assign light_err = err_q;

endmodule

// File: tb/tb_cntry_vehicle_sensor.sv
// Bench for cntry_vehicle_sensor: vector table plus hand-written corner sequences,
// expected outputs queued on drive and popped when sampled.
module tb_cntry_vehicle_sensor;
  import cntry_vehicle_sensor_pkg::*;

  typedef struct {
    logic        raw;
    logic [1:0]  code;
    int unsigned cycles;
    logic [3:0]  q;
    logic        x;
    logic        ov;
    logic        err;
  } vec_t;

  typedef logic [6:0] exp_t;  // {queue_cnt, X, overflow, light_err}

  logic       clock = 1'b0;
  logic       clear_n;
  logic       loop_raw;
  logic [1:0] cntry;
  logic       X;
  logic [3:0] queue_cnt;
  logic       overflow;
  logic       light_err;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  vec_t tbl[$];

  cntry_vehicle_sensor dut (
    .clock    (clock),
    .clear_n  (clear_n),
    .loop_raw (loop_raw),
    .cntry    (cntry),
    .X        (X),
    .queue_cnt(queue_cnt),
    .overflow (overflow),
    .light_err(light_err)
  );

  always #5 clock = ~clock;

  function automatic vec_t mkv(input logic raw, input logic [1:0] code, input int unsigned n,
                               input int q, input logic x, input logic ov, input logic err);
    vec_t v;
    v.raw = raw; v.code = code; v.cycles = n;
    v.q = 4'(q); v.x = x; v.ov = ov; v.err = err;
    return v;
  endfunction

  task automatic check(input string tag);
    exp_t e, a;
    a = {queue_cnt, X, overflow, light_err};
    total++;
    if (sb_q.size() == 0) begin
      bad++;
      $display("FAIL %s: scoreboard empty, got q=%0d X=%b ovf=%b err=%b",
               tag, a[6:3], a[2], a[1], a[0]);
    end else begin
      e = sb_q.pop_front();
      if (a !== e) begin
        bad++;
        $display("FAIL %s: got q=%0d X=%b ovf=%b err=%b, want q=%0d X=%b ovf=%b err=%b",
                 tag, a[6:3], a[2], a[1], a[0], e[6:3], e[2], e[1], e[0]);
      end
    end
  endtask

  // Entered 1 time unit after a posedge; drives, runs v.cycles edges, samples 1 unit after.
  task automatic apply(input vec_t v, input string tag);
    loop_raw = v.raw;
    cntry    = v.code;
    sb_q.push_back({v.q, v.x, v.ov, v.err});
    repeat (v.cycles) @(posedge clock);
    #1 check(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    clear_n  = 1'b0;
    loop_raw = 1'b0;
    cntry    = LightRed;

    // Glitch, first arrival latency, hold/release, second arrival, green drain of two.
    tbl.push_back(mkv(0, LightRed,    3, 0, 0, 0, 0));
    tbl.push_back(mkv(1, LightRed,    3, 0, 0, 0, 0));
    tbl.push_back(mkv(0, LightRed,    8, 0, 0, 0, 0));
    tbl.push_back(mkv(1, LightRed,    6, 0, 0, 0, 0));
    tbl.push_back(mkv(1, LightRed,    1, 1, 1, 0, 0));
    tbl.push_back(mkv(1, LightRed,   10, 1, 1, 0, 0));
    tbl.push_back(mkv(0, LightRed,   10, 1, 1, 0, 0));
    tbl.push_back(mkv(1, LightRed,    7, 2, 1, 0, 0));
    tbl.push_back(mkv(0, LightRed,    8, 2, 1, 0, 0));
    tbl.push_back(mkv(0, LightGreen,  2, 2, 1, 0, 0));
    tbl.push_back(mkv(0, LightGreen,  1, 1, 1, 0, 0));
    tbl.push_back(mkv(0, LightGreen,  2, 1, 1, 0, 0));
    tbl.push_back(mkv(0, LightGreen,  1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, LightGreen,  1, 0, 0, 0, 0));
    tbl.push_back(mkv(0, LightYellow, 2, 0, 0, 0, 0));

    repeat (3) @(posedge clock);
    #1;
    sb_q.push_back('0);
    check("reset_hold");
    clear_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Arrival coincident with departure at queue 1, then an illegal light code mid-green.
    apply(mkv(1, LightRed,     7, 1, 1, 0, 0), "coin_setup_arr");
    apply(mkv(0, LightRed,     8, 1, 1, 0, 0), "coin_setup_rel");
    apply(mkv(1, LightRed,     4, 1, 1, 0, 0), "coin_red");
    apply(mkv(1, LightGreen,   2, 1, 1, 0, 0), "coin_green");
    apply(mkv(1, LightGreen,   1, 1, 1, 0, 0), "coin_edge");
    apply(mkv(1, LightGreen,   1, 1, 1, 0, 0), "illegal_pre");
    apply(mkv(1, LightIllegal, 1, 1, 1, 0, 1), "illegal_code");
    apply(mkv(1, LightGreen,   2, 1, 1, 0, 1), "illegal_tmr_clr");
    apply(mkv(1, LightGreen,   1, 0, 0, 0, 1), "illegal_depart");
    apply(mkv(0, LightRed,     8, 0, 0, 0, 1), "illegal_release");

    // Sixteen arrivals saturate at 15 and set overflow.
    for (int i = 1; i <= 16; i++) begin
      apply(mkv(1, LightRed, 7, (i > 15) ? 15 : i, 1, (i == 16), 1), $sformatf("sat_arr%0d", i));
      apply(mkv(0, LightRed, 7, (i > 15) ? 15 : i, 1, (i == 16), 1), $sformatf("sat_rel%0d", i));
    end
    apply(mkv(0, LightGreen, 44, 1, 1, 1, 1), "drain_44");
    apply(mkv(0, LightGreen,  1, 0, 0, 1, 1), "drain_45");
    apply(mkv(0, LightGreen,  3, 0, 0, 1, 1), "no_underflow");
    apply(mkv(0, LightRed,    2, 0, 0, 1, 1), "drain_red");

    for (int i = 1; i <= 5; i++) begin
      apply(mkv(1, LightRed, 7, i, 1, 1, 1), $sformatf("five_arr%0d", i));
      apply(mkv(0, LightRed, 7, i, 1, 1, 1), $sformatf("five_rel%0d", i));
    end
    apply(mkv(1, LightRed, 3, 5, 1, 1, 1), "mid_debounce");

    // Asynchronous reset between edges, with a debounce in progress.
    #1 clear_n = 1'b0;
    #1;
    sb_q.push_back('0);
    check("async_reset");
    #1 clear_n = 1'b1;
    @(posedge clock);
    #1;
    sb_q.push_back('0);
    check("post_reset");
    apply(mkv(1, LightRed, 5, 0, 0, 0, 0), "restart_wait");
    apply(mkv(1, LightRed, 1, 1, 1, 0, 0), "restart_arr");

    if (sb_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
